// File: rtl/i2s_pkg.sv
// Constants and helpers shared between the I2S transmitter and the downstream converter.
package i2s_pkg;

  localparam int I2S_BIT  = 24;
  localparam int I2S_SLOT = 32;

  localparam logic LRCK_LEFT = 1'b1;

  // Two's-complement midscale, sent whenever no sample pair is available.
  localparam logic [I2S_BIT-1:0] I2S_MIDSCALE = '0;

  typedef enum logic {
    CH_LEFT  = 1'b0,
    CH_RIGHT = 1'b1
  } i2s_chan_e;

  function automatic logic lrck_for(input i2s_chan_e ch);
    return (ch == CH_LEFT) ? LRCK_LEFT : ~LRCK_LEFT;
  endfunction

endpackage

// File: rtl/i2s_tx_master_if.sv
// Parallel stereo sample handshake into the I2S transmitter.
interface i2s_tx_master_if
  import i2s_pkg::*;
#(
  parameter int BIT = I2S_BIT
) ();

  logic [BIT-1:0] l_data;
  logic [BIT-1:0] r_data;
  logic           valid;
  logic           ready;

  modport master (output l_data, output r_data, output valid, input ready);
  modport slave  (input l_data, input r_data, input valid, output ready);

endinterface

// File: rtl/i2s_bck_gen.sv
// Bit-clock divider: registered bck and a strobe for the cycle bck goes high.
module i2s_bck_gen #(
  parameter int BCK_DIV = 8
) (
  input  logic mck_i,
  input  logic rst_i,
  output logic bck_o,
  output logic bck_rise_o
);

  localparam int DW = $clog2(BCK_DIV);
  localparam logic [DW-1:0] HALF = DW'(BCK_DIV / 2);
  localparam logic [DW-1:0] LAST = DW'(BCK_DIV - 1);

  logic [DW-1:0] div_q, div_d;
  logic          bck_q, bck_d;

  always_comb begin
    div_d      = (div_q == LAST) ? '0 : div_q + DW'(1);
    bck_d      = (div_d >= HALF);
    bck_rise_o = (div_d == HALF);
  end

  always_ff @(posedge mck_i or posedge rst_i) begin
    if (rst_i) begin
      div_q <= '0;
      bck_q <= 1'b0;
    end else begin
      div_q <= div_d;
      bck_q <= bck_d;
    end
  end

  assign bck_o = bck_q;

endmodule

// File: rtl/i2s_tx_master.sv
// I2S master transmitter: one-entry stereo buffer feeding per-channel shift registers,
// framed by a bit counter that advances on each bck rising strobe.
module i2s_tx_master
  import i2s_pkg::*;
#(
  parameter int BIT     = I2S_BIT,
  parameter int SLOT    = I2S_SLOT,
  parameter int BCK_DIV = 8
) (
  input  logic                  mck_i,
  input  logic                  rst_i,
  i2s_tx_master_if.slave        smp_i,
  output logic                  mck_o,
  output logic                  bck_o,
  output logic                  lrck_o,
  output logic                  data_o,
  output logic                  underrun_o
);

  localparam int CW = $clog2(2 * SLOT);
  localparam logic [CW-1:0] CNT_LAST = CW'(2 * SLOT - 1);
  localparam logic [CW-1:0] SLOT_C   = CW'(SLOT);
  localparam logic [CW-1:0] BIT_C    = CW'(BIT);

  logic           bck_rise;
  logic           frame_start;
  logic           accept;
  i2s_chan_e      chan;
  logic [CW-1:0]  slot_pos;

  logic [CW-1:0]  bit_cnt_q, bit_cnt_d;
  logic [BIT-1:0] buf_l_q, buf_l_d;
  logic [BIT-1:0] buf_r_q, buf_r_d;
  logic [BIT-1:0] sh_l_q, sh_l_d;
  logic [BIT-1:0] sh_r_q, sh_r_d;
  logic           ready_q, ready_d;
  logic           lrck_q, lrck_d;
  logic           data_q, data_d;
  logic           und_q, und_d;

  i2s_bck_gen #(
    .BCK_DIV (BCK_DIV)
  ) u_bck_gen (
    .mck_i      (mck_i),
    .rst_i      (rst_i),
    .bck_o      (bck_o),
    .bck_rise_o (bck_rise)
  );

  // ready_q low means the buffer holds a pair, so accept can never hit a full buffer.
  assign accept      = smp_i.valid && ready_q;
  assign frame_start = bck_rise && (bit_cnt_q == CNT_LAST);

  always_comb begin
    bit_cnt_d = bit_cnt_q;
    buf_l_d   = buf_l_q;
    buf_r_d   = buf_r_q;
    sh_l_d    = sh_l_q;
    sh_r_d    = sh_r_q;
    ready_d   = ready_q;
    lrck_d    = lrck_q;
    data_d    = data_q;
    und_d     = 1'b0;

    if (bck_rise) begin
      bit_cnt_d = frame_start ? '0 : bit_cnt_q + CW'(1);
    end
    chan     = (bit_cnt_d >= SLOT_C) ? CH_RIGHT : CH_LEFT;
    slot_pos = (chan == CH_RIGHT) ? bit_cnt_d - SLOT_C : bit_cnt_d;

    if (accept) begin
      buf_l_d = smp_i.l_data;
      buf_r_d = smp_i.r_data;
      ready_d = 1'b0;
    end

    if (frame_start) begin
      if (!ready_q) begin
        sh_l_d  = buf_l_q;
        sh_r_d  = buf_r_q;
        ready_d = 1'b1;
      end else begin
        sh_l_d = BIT'(I2S_MIDSCALE);
        sh_r_d = BIT'(I2S_MIDSCALE);
        und_d  = 1'b1;
      end
    end

    // Slot position 0 is the one-bit I2S delay; positions past BIT are zero padding.
    if (bck_rise) begin
      lrck_d = lrck_for(chan);
      data_d = 1'b0;
      if ((slot_pos != '0) && (slot_pos <= BIT_C)) begin
        if (chan == CH_LEFT) begin
          data_d = sh_l_q[BIT-1];
          sh_l_d = sh_l_q << 1;
        end else begin
          data_d = sh_r_q[BIT-1];
          sh_r_d = sh_r_q << 1;
        end
      end
    end
  end

  always_ff @(posedge mck_i or posedge rst_i) begin
    if (rst_i) begin
      bit_cnt_q <= CNT_LAST;
      buf_l_q   <= '0;
      buf_r_q   <= '0;
      sh_l_q    <= '0;
      sh_r_q    <= '0;
      ready_q   <= 1'b1;
      lrck_q    <= 1'b0;
      data_q    <= 1'b0;
      und_q     <= 1'b0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
      buf_l_q   <= buf_l_d;
      buf_r_q   <= buf_r_d;
      sh_l_q    <= sh_l_d;
      sh_r_q    <= sh_r_d;
      ready_q   <= ready_d;
      lrck_q    <= lrck_d;
      data_q    <= data_d;
      und_q     <= und_d;
    end
  end

  assign smp_i.ready = ready_q;
  assign mck_o       = mck_i;
  assign lrck_o      = lrck_q;
  assign data_o      = data_q;
  assign underrun_o  = und_q;

endmodule

// File: tb/tb_i2s_tx_master.sv
// Scoreboard bench for i2s_tx_master: stimulus queues expected frames, a monitor
// reassembles each serial frame and compares it against the queue.
module tb_i2s_tx_master;

  localparam int BIT     = 24;
  localparam int SLOT    = 32;
  localparam int BCK_DIV = 8;
  localparam int FRAME   = 2 * SLOT * BCK_DIV;

  logic mck = 1'b0;
  logic rst = 1'b1;
  logic mck_o, bck, lrck, data, und;

  i2s_tx_master_if #(.BIT(BIT)) smp ();

  i2s_tx_master #(
    .BIT     (BIT),
    .SLOT    (SLOT),
    .BCK_DIV (BCK_DIV)
  ) dut (
    .mck_i      (mck),
    .rst_i      (rst),
    .smp_i      (smp),
    .mck_o      (mck_o),
    .bck_o      (bck),
    .lrck_o     (lrck),
    .data_o     (data),
    .underrun_o (und)
  );

  always #5 mck = ~mck;

  typedef struct {
    logic [23:0] l;
    logic [23:0] r;
    int          und;
  } frame_t;

  frame_t exp_q[$];
  int     n_assert = 0;
  int     n_fail = 0;
  int     frames_done = 0;
  longint cyc = 0;

  always @(posedge mck) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_assert++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // ---------------- monitor ----------------
  logic bits_a[64];
  logic lr_a[64];
  int   idx;
  bit   active;
  logic pb, pl, pr;
  int   und_cnt;

  task automatic compare_frame();
    logic [23:0] lw, rw;
    int pad_nz, lr_bad;
    frame_t e;
    pad_nz = 0;
    lr_bad = 0;
    for (int k = 1; k <= 24; k++) begin
      lw[24-k] = bits_a[k];
      rw[24-k] = bits_a[32+k];
    end
    for (int k = 0; k < 64; k++) begin
      if ((k % 32 == 0 || k % 32 > 24) && bits_a[k] !== 1'b0) pad_nz++;
      if (lr_a[k] !== ((k < 32) ? 1'b1 : 1'b0)) lr_bad++;
    end
    check("pad_zero_bits", 32'(pad_nz), 32'd0);
    check("lrck_pattern", 32'(lr_bad), 32'd0);
    if (exp_q.size() == 0) begin
      n_assert++;
      n_fail++;
      $display("FAIL scoreboard_empty: got frame L=0x%06h R=0x%06h, expected no frame", lw, rw);
    end else begin
      e = exp_q.pop_front();
      check("left_word", 32'(lw), 32'(e.l));
      check("right_word", 32'(rw), 32'(e.r));
      check("underrun_count", 32'(und_cnt), 32'(e.und));
      $display("frame %0d: L=0x%06h R=0x%06h underruns=%0d (exp L=0x%06h R=0x%06h und=%0d)",
               frames_done, lw, rw, und_cnt, e.l, e.r, e.und);
    end
    frames_done++;
  endtask

  initial begin
    active = 0; idx = 0; pb = 0; pl = 0; pr = 1; und_cnt = 0;
    forever begin
      @(negedge mck);
      if (rst) begin
        active = 0; idx = 0; pb = 0; pl = 0; pr = 1; und_cnt = 0;
      end else begin
        if (bck && !pb && lrck && !pl) begin
          active  = 1;
          idx     = 0;
          und_cnt = 0;
          // Each frame start either releases the buffer or reports an underrun.
          check("ready_rise_xor_underrun", 32'((smp.ready && !pr) ^ und), 32'd1);
        end
        if (active && und) und_cnt++;
        if (active && bck && !pb) begin
          bits_a[idx] = data;
          lr_a[idx]   = lrck;
          idx++;
          if (idx == 64) begin
            compare_frame();
            active = 0;
          end
        end
        pb = bck;
        pl = lrck;
        pr = smp.ready;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic send_pair(input logic [23:0] l, input logic [23:0] r, output longint acc);
    int n;
    smp.l_data = l;
    smp.r_data = r;
    smp.valid  = 1'b1;
    n = 0;
    while (!smp.ready && n < 2 * FRAME) begin
      @(negedge mck);
      n++;
    end
    acc = cyc;
    check("accept_in_time", 32'(smp.ready), 32'd1);
    if (smp.ready) begin
      exp_q.push_back('{l, r, 0});
      $display("accept L=0x%06h R=0x%06h at cycle %0d", l, r, cyc);
    end
    @(negedge mck);
  endtask

  task automatic wait_frames(input int target);
    int n;
    n = 0;
    while (frames_done < target && n < 4 * FRAME) begin
      @(negedge mck);
      n++;
    end
    check("frames_completed", 32'(frames_done >= target), 32'd1);
  endtask

  initial begin
    int     n, base;
    longint acc[6];
    longint dummy;

    smp.valid  = 1'b0;
    smp.l_data = '0;
    smp.r_data = '0;

    // Reset, no valid: first frame underruns, all data bits zero.
    rst = 1'b1;
    repeat (3) @(negedge mck);
    check("rst_ready", 32'(smp.ready), 32'd1);
    check("rst_bck", 32'(bck), 32'd0);
    check("rst_lrck", 32'(lrck), 32'd0);
    check("rst_data", 32'(data), 32'd0);
    check("rst_underrun", 32'(und), 32'd0);
    check("mck_passthrough", 32'(mck_o), 32'(mck));
    exp_q.push_back('{24'h000000, 24'h000000, 1});
    base = frames_done;
    rst  = 1'b0;
    n = 0;
    while (!bck && n < 20) begin
      @(negedge mck);
      n++;
    end
    check("first_bck_rise_mck", 32'(n), 32'd4);
    check("lrck_at_first_rise", 32'(lrck), 32'd1);
    wait_frames(base + 1);

    // Pair accepted ahead of the first frame, then a back-to-back stream.
    rst = 1'b1;
    exp_q.delete();
    repeat (3) @(negedge mck);
    base = frames_done;
    rst  = 1'b0;
    send_pair(24'h800001, 24'h7FFFFE, dummy);
    for (int i = 0; i < 4; i++) begin
      send_pair(24'(i), 24'hABC000 + 24'(i), acc[i]);
      if (i > 0) check("accept_interval", 32'(acc[i] - acc[i-1]), 32'(FRAME));
    end

    // Withhold one frame's data.
    smp.valid = 1'b0;
    n = 0;
    while (!und && n < 3 * FRAME) begin
      @(negedge mck);
      n++;
    end
    check("withheld_underrun", 32'(und), 32'd1);
    exp_q.push_back('{24'h000000, 24'h000000, 1});
    send_pair(24'h5A5A5A, 24'hA5A5A5, dummy);
    send_pair(24'h123456, 24'hFEDCBA, dummy);
    smp.valid = 1'b0;
    wait_frames(base + 6);

    // Reset in the middle of the right slot with a pair still buffered.
    n = 0;
    while (lrck && n < FRAME) begin
      @(negedge mck);
      n++;
    end
    for (int b = 0; b < 3; b++) begin
      n = 0;
      @(negedge mck);
      while (bck && n < 2 * BCK_DIV) begin @(negedge mck); n++; end
      while (!bck && n < 2 * BCK_DIV) begin @(negedge mck); n++; end
    end
    @(posedge mck);
    #2;
    check("pre_rst_ready_low", 32'(smp.ready), 32'd0);
    check("pre_rst_bck_high", 32'(bck), 32'd1);
    rst = 1'b1;
    #1;
    check("async_rst_bck", 32'(bck), 32'd0);
    check("async_rst_lrck", 32'(lrck), 32'd0);
    check("async_rst_data", 32'(data), 32'd0);
    check("async_rst_ready", 32'(smp.ready), 32'd1);
    check("async_rst_underrun", 32'(und), 32'd0);
    exp_q.delete();
    exp_q.push_back('{24'h000000, 24'h000000, 1});
    repeat (2) @(negedge mck);
    base = frames_done;
    rst  = 1'b0;
    wait_frames(base + 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    n_assert++;
    n_fail++;
    $display("FAIL watchdog: got no end of test, expected completion within 1000000 time units");
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
